cordic_atanh_vec: RTL

- Sequential hyperbolic CORDIC engine in vectoring mode. Computes z = atanh(y0/x0) for fixed-point inputs in the [3:-13] format (17-bit signed, 13 fractional bits).
- It is the reading end of the hyperbolic angle-table interface. It drives the 5-bit table index and consumes the 17-bit angle that the combinational table returns in the same cycle.
- It is the inverse-direction companion to the rotation-mode tanh path, and reuses the same extended-range angle schedule.

---
 rtl/cordic_atanh_vec_if.sv | 23 ++
 rtl/cordic_atanh_vec.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cordic_atanh_vec_if.sv
// Request/result and angle-table signals of the hyperbolic vectoring CORDIC.
// master: requester plus angle table; slave: the CORDIC engine.
interface cordic_atanh_vec_if;
    logic               start;
    logic signed [16:0] x_in;
    logic signed [16:0] y_in;
    logic        [4:0]  ang_idx;
    logic signed [16:0] ang_val;
    logic               busy;
    logic               done;
    logic               err;
    logic signed [16:0] z_out;

    modport master (
        output start, x_in, y_in, ang_val,
        input  ang_idx, busy, done, err, z_out
    );

    modport slave (
        input  start, x_in, y_in, ang_val,
        output ang_idx, busy, done, err, z_out
    );
endinterface

// File: rtl/cordic_atanh_vec.sv
// Sequential hyperbolic CORDIC, vectoring mode: z = atanh(y0/x0) in [3:-13].
// Latency: done follows the start edge by 25 edges (1 edge on a domain error).
// No backpressure: start is sampled only in IDLE; starts while busy are dropped.
module cordic_atanh_vec #(
    parameter int IW       = 25,
    parameter int ZW       = 20,
    parameter int LAST_IDX = 22,
    parameter int REP_IDX  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_atanh_vec_if.slave io
);

    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2} state_t;

    localparam logic signed [ZW-3:0] ZMAX = (ZW-2)'(65535);
    localparam logic signed [ZW-3:0] ZMIN = (ZW-2)'(-65536);

    state_t               state_q, state_d;
    logic signed [IW-1:0] x_q, y_q, x_nx, y_nx, x_sh, y_sh, dx, dy;
    logic signed [ZW-1:0] z_q, z_nx, ang_sh;
    logic signed [ZW-3:0] z_rnd;
    logic        [4:0]    idx_q, sh;
    logic                 rep_q, err_q, done_q;
    logic signed [16:0]   z_out_q, z_res;
    logic signed [17:0]   x_ext, y_ext, y_abs;
    logic                 dom_err, neg_stage, d_pos, last_iter, rep_hold;

    // Domain check on the raw operands, evaluated in the accepting cycle.
    assign x_ext   = 18'(io.x_in);
    assign y_ext   = 18'(io.y_in);
    assign y_abs   = y_ext[17] ? -y_ext : y_ext;
    assign dom_err = (x_ext <= 18'sd0) || (y_abs >= x_ext);

    // Indices 0..10 are the extended-range stages using (1 - 2^-s).
    assign neg_stage = (idx_q <= 5'd10);
    assign sh        = neg_stage ? (5'd12 - idx_q) : (idx_q - 5'd10);
    assign x_sh      = x_q >>> sh;
    assign y_sh      = y_q >>> sh;
    assign dx        = neg_stage ? (y_q - y_sh) : y_sh;
    assign dy        = neg_stage ? (x_q - x_sh) : x_sh;
    assign d_pos     = y_q[IW-1];
    assign x_nx      = d_pos ? (x_q + dx) : (x_q - dx);
    assign y_nx      = d_pos ? (y_q + dy) : (y_q - dy);
    assign ang_sh    = ZW'(io.ang_val) <<< 3;
    assign z_nx      = d_pos ? (z_q - ang_sh) : (z_q + ang_sh);

    assign last_iter = (idx_q == 5'(LAST_IDX));
    assign rep_hold  = (idx_q == 5'(REP_IDX)) && !rep_q;

    // Round half up from 16 to 13 fraction bits.
    assign z_rnd = (ZW-2)'(((ZW+1)'(z_q) + (ZW+1)'(4)) >>> 3);

    // On a domain error y_q still holds the latched numerator.
    always_comb begin
        z_res = '0;
        if (err_q) begin
            if (y_q == '0)
                z_res = '0;
            else if (y_q[IW-1])
                z_res = 17'sh10000;
            else
                z_res = 17'sh0FFFF;
        end else if (z_rnd > ZMAX) begin
            z_res = 17'sh0FFFF;
        end else if (z_rnd < ZMIN) begin
            z_res = 17'sh10000;
        end else begin
            z_res = 17'(z_rnd);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (io.start) state_d = dom_err ? FIN : ITER;
            ITER: if (last_iter) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            z_out_q <= '0;
        end else begin
            done_q <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (io.start) begin
                        x_q   <= IW'(io.x_in) <<< 5;
                        y_q   <= IW'(io.y_in) <<< 5;
                        z_q   <= '0;
                        idx_q <= '0;
                        rep_q <= 1'b0;
                        err_q <= dom_err;
                    end
                end
                ITER: begin
                    x_q <= x_nx;
                    y_q <= y_nx;
                    z_q <= z_nx;
                    if (rep_hold)
                        rep_q <= 1'b1;
                    else if (last_iter)
                        idx_q <= '0;
                    else
                        idx_q <= idx_q + 5'd1;
                end
                FIN: z_out_q <= z_res;
                default: ;
            endcase
        end
    end

    assign io.busy    = (state_q == ITER);
    assign io.done    = done_q;
    assign io.err     = err_q;
    assign io.z_out   = z_out_q;
    assign io.ang_idx = (state_q == ITER) ? idx_q : 5'd0;

endmodule
